// File: rtl/bp_be_rf_write_sched_pkg.sv
// Shared types and constants for the backend regfile write-port scheduler.
// The register address width stands in for the processor config value.
package bp_be_rf_write_sched_pkg;

    localparam int reg_addr_width_gp = 5;

    typedef enum logic {
        e_rf_sched_init,
        e_rf_sched_run
    } rf_sched_state_e;

endpackage

// File: rtl/bp_be_rf_write_sched_if.sv
// Bus bundle between the writeback sources, the scheduler and the regfile
// write port. The master drives requests; the slave (the scheduler) drives the
// regfile write and the grants.
interface bp_be_rf_write_sched_if
    import bp_be_rf_write_sched_pkg::*;
#(
    parameter int data_width_p = 32,
    parameter int late_ports_p = 2
) ();

    logic                                                 pipe_v_i;
    logic [reg_addr_width_gp-1:0]                         pipe_addr_i;
    logic [data_width_p-1:0]                              pipe_data_i;
    logic [late_ports_p-1:0]                              late_v_i;
    logic [late_ports_p-1:0][reg_addr_width_gp-1:0]       late_addr_i;
    logic [late_ports_p-1:0][data_width_p-1:0]            late_data_i;
    logic [late_ports_p-1:0]                              late_ready_o;
    logic                                                 rd_w_v_o;
    logic [reg_addr_width_gp-1:0]                         rd_addr_o;
    logic [data_width_p-1:0]                              rd_data_o;
    logic                                                 init_done_o;
    logic                                                 stall_req_o;

    modport master (
        output pipe_v_i, pipe_addr_i, pipe_data_i,
        output late_v_i, late_addr_i, late_data_i,
        input  late_ready_o, rd_w_v_o, rd_addr_o, rd_data_o,
        input  init_done_o, stall_req_o
    );

    modport slave (
        input  pipe_v_i, pipe_addr_i, pipe_data_i,
        input  late_v_i, late_addr_i, late_data_i,
        output late_ready_o, rd_w_v_o, rd_addr_o, rd_data_o,
        output init_done_o, stall_req_o
    );

endinterface

// File: rtl/bp_be_rf_write_sched_rr.sv
// Round-robin arbiter: grants the first requester at or after the pointer and
// moves the pointer just past the grantee whenever a grant is issued.
module bp_be_rf_write_sched_rr #(
    parameter int width_p = 2
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               en_i,
    input  logic [width_p-1:0] reqs_i,
    output logic [width_p-1:0] grants_o
);

    localparam int ptr_width_lp = (width_p > 1) ? $clog2(width_p) : 1;
    typedef logic [ptr_width_lp-1:0] ptr_t;

    ptr_t ptr_q, ptr_n, grant_idx;
    logic hit;

    // Two passes: requesters at/after the pointer first, then wrap to the low ones.
    always_comb begin
        grants_o  = '0;
        hit       = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < width_p; i++) begin
            if (!hit && reqs_i[i] && (ptr_t'(i) >= ptr_q)) begin
                hit       = 1'b1;
                grant_idx = ptr_t'(i);
            end
        end
        for (int i = 0; i < width_p; i++) begin
            if (!hit && reqs_i[i]) begin
                hit       = 1'b1;
                grant_idx = ptr_t'(i);
            end
        end
        ptr_n = ptr_q;
        if (en_i && hit) begin
            grants_o[grant_idx] = 1'b1;
            ptr_n = (grant_idx == ptr_t'(width_p - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_n;
        end
    end

endmodule

// File: rtl/bp_be_rf_write_sched.sv
// Regfile write-port scheduler: zero-sweeps the regfile after reset, then
// merges pipeline writeback (top priority) with round-robin late writebacks.
module bp_be_rf_write_sched
    import bp_be_rf_write_sched_pkg::*;
#(
    parameter int data_width_p   = 32,
    parameter int late_ports_p   = 2,
    parameter int init_zero_p    = 1,
    parameter int starve_limit_p = 8
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    bp_be_rf_write_sched_if.slave       bus
);

    localparam int starve_width_lp = $clog2(starve_limit_p + 1);
    typedef logic [starve_width_lp-1:0] starve_t;
    localparam starve_t starve_max_lp = starve_t'(starve_limit_p);

    rf_sched_state_e              state_q, state_n;
    logic [reg_addr_width_gp-1:0] sweep_q;
    starve_t                      starve_q, starve_n;
    logic                         stall_q;
    logic                         arb_en;
    logic [late_ports_p-1:0]      grants;

    bp_be_rf_write_sched_rr #(.width_p(late_ports_p)) arb (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .en_i      (arb_en),
        .reqs_i    (bus.late_v_i),
        .grants_o  (grants)
    );

    always_comb begin
        state_n          = state_q;
        arb_en           = 1'b0;
        bus.rd_w_v_o     = 1'b0;
        bus.rd_addr_o    = bus.pipe_addr_i;
        bus.rd_data_o    = bus.pipe_data_i;
        bus.init_done_o  = 1'b0;
        starve_n         = '0;
        case (state_q)
            e_rf_sched_init: begin
                bus.rd_w_v_o  = 1'b1;
                bus.rd_addr_o = sweep_q;
                bus.rd_data_o = {data_width_p{1'b0}};
                if (sweep_q == '1) begin
                    state_n = e_rf_sched_run;
                end
            end
            default: begin
                bus.init_done_o = 1'b1;
                arb_en          = !bus.pipe_v_i;
                if (bus.pipe_v_i) begin
                    bus.rd_w_v_o = 1'b1;
                end else begin
                    for (int i = 0; i < late_ports_p; i++) begin
                        if (grants[i]) begin
                            bus.rd_w_v_o  = 1'b1;
                            bus.rd_addr_o = bus.late_addr_i[i];
                            bus.rd_data_o = bus.late_data_i[i];
                        end
                    end
                end
                // A late source that wants the port but loses counts as starved.
                starve_n = starve_q;
                if (|grants) begin
                    starve_n = '0;
                end else if ((|bus.late_v_i) && (starve_q != starve_max_lp)) begin
                    starve_n = starve_q + 1'b1;
                end
            end
        endcase
    end

    assign bus.late_ready_o = grants;
    assign bus.stall_req_o  = stall_q;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q  <= (init_zero_p != 0) ? e_rf_sched_init : e_rf_sched_run;
            sweep_q  <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
        end else begin
            state_q  <= state_n;
            sweep_q  <= (state_q == e_rf_sched_init) ? sweep_q + 1'b1 : sweep_q;
            starve_q <= starve_n;
            stall_q  <= (starve_n == starve_max_lp);
        end
    end

    // The sweep owns the port; the pipeline must not write before init is done.
    always_ff @(posedge clk_i) begin
        if (reset_n_i && (state_q == e_rf_sched_init)) begin
            assert (!bus.pipe_v_i);
        end
    end

endmodule

// File: tb/tb_bp_be_rf_write_sched.sv
// Self-checking bench for bp_be_rf_write_sched: directed vectors, multi-cycle
// sequences and randomized traffic against a behavioural scheduler model.
module tb_bp_be_rf_write_sched;
    import bp_be_rf_write_sched_pkg::*;

    localparam int dw         = 32;
    localparam int np         = 2;
    localparam int aw         = reg_addr_width_gp;
    localparam int nregs      = 1 << aw;
    localparam int starve_lim = 8;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    bp_be_rf_write_sched_if #(.data_width_p(dw), .late_ports_p(np)) bus ();
    bp_be_rf_write_sched_if #(.data_width_p(dw), .late_ports_p(np)) bus_nz ();

    bp_be_rf_write_sched #(
        .data_width_p(dw), .late_ports_p(np), .init_zero_p(1), .starve_limit_p(starve_lim)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n), .bus(bus)
    );

    bp_be_rf_write_sched #(
        .data_width_p(dw), .late_ports_p(np), .init_zero_p(0), .starve_limit_p(starve_lim)
    ) dut_nz (
        .clk_i(clk), .reset_n_i(reset_n), .bus(bus_nz)
    );

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic          pv;
        logic [aw-1:0] pa;
        logic [dw-1:0] pd;
        logic [np-1:0] lv;
        logic [aw-1:0] la0, la1;
        logic [dw-1:0] ld0, ld1;
        logic          ev;
        logic [aw-1:0] ea;
        logic [dw-1:0] ed;
        logic [np-1:0] er;
        logic          es;
    } vec_t;

    vec_t tbl [9];

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] want);
        n_vec++;
        if (act !== want) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
        end
    endtask

    task automatic apply_stimulus(input logic pv, input logic [aw-1:0] pa, input logic [dw-1:0] pd,
                                  input logic [np-1:0] lv,
                                  input logic [aw-1:0] la0, input logic [aw-1:0] la1,
                                  input logic [dw-1:0] ld0, input logic [dw-1:0] ld1);
        bus.pipe_v_i       = pv;
        bus.pipe_addr_i    = pa;
        bus.pipe_data_i    = pd;
        bus.late_v_i       = lv;
        bus.late_addr_i[0] = la0;
        bus.late_addr_i[1] = la1;
        bus.late_data_i[0] = ld0;
        bus.late_data_i[1] = ld1;
    endtask

    task automatic check_write(input string tag, input logic ev, input logic [aw-1:0] ea,
                               input logic [dw-1:0] ed, input logic [np-1:0] er, input logic es);
        check_output({tag, " rd_w_v"}, bus.rd_w_v_o, ev);
        if (ev) begin
            check_output({tag, " rd_addr"}, bus.rd_addr_o, ea);
            check_output({tag, " rd_data"}, bus.rd_data_o, ed);
        end
        check_output({tag, " late_ready"}, bus.late_ready_o, er);
        check_output({tag, " stall_req"}, bus.stall_req_o, es);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_sweep(input string tag);
        for (int i = 0; i < nregs; i++) begin
            #3;
            check_output($sformatf("%s sweep v %0d", tag, i), bus.rd_w_v_o, 1'b1);
            check_output($sformatf("%s sweep addr %0d", tag, i), bus.rd_addr_o, i);
            check_output($sformatf("%s sweep data %0d", tag, i), bus.rd_data_o, 0);
            check_output($sformatf("%s sweep ready %0d", tag, i), bus.late_ready_o, 0);
            check_output($sformatf("%s sweep done %0d", tag, i), bus.init_done_o, 0);
            next_cycle();
        end
        #3;
        check_output({tag, " init_done after sweep"}, bus.init_done_o, 1'b1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int ptr;
        int starve;
        int g;
        logic          pend [np];
        logic [aw-1:0] paddr [np];
        logic [dw-1:0] pdata [np];
        logic          pv;
        logic [aw-1:0] pa;
        logic [dw-1:0] pd;
        logic [np-1:0] lv;
        logic [np-1:0] er;

        reset_n = 1'b0;
        apply_stimulus(1'b0, '0, '0, '0, '0, '0, '0, '0);
        bus_nz.pipe_v_i = 1'b0; bus_nz.pipe_addr_i = '0; bus_nz.pipe_data_i = '0;
        bus_nz.late_v_i = '0; bus_nz.late_addr_i = '0; bus_nz.late_data_i = '0;
        repeat (2) next_cycle();

        // Reset state of both configurations.
        #3;
        check_output("reset rd_w_v", bus.rd_w_v_o, 1'b1);
        check_output("reset rd_addr", bus.rd_addr_o, 0);
        check_output("reset init_done", bus.init_done_o, 1'b0);
        check_output("reset late_ready", bus.late_ready_o, 0);
        check_output("reset stall_req", bus.stall_req_o, 1'b0);
        check_output("nz reset init_done", bus_nz.init_done_o, 1'b1);
        check_output("nz reset rd_w_v", bus_nz.rd_w_v_o, 1'b0);
        reset_n = 1'b1;
        #1;

        // Sweep on the main DUT while the no-init DUT serves a late request immediately.
        for (int i = 0; i < nregs; i++) begin
            bus_nz.late_v_i       = (i == 1) ? 2'b10 : 2'b00;
            bus_nz.late_addr_i[1] = 5'd9;
            bus_nz.late_data_i[1] = 32'h99;
            #3;
            check_output($sformatf("sweep v %0d", i), bus.rd_w_v_o, 1'b1);
            check_output($sformatf("sweep addr %0d", i), bus.rd_addr_o, i);
            check_output($sformatf("sweep data %0d", i), bus.rd_data_o, 0);
            check_output($sformatf("sweep ready %0d", i), bus.late_ready_o, 0);
            check_output($sformatf("sweep done %0d", i), bus.init_done_o, 0);
            if (i == 0) check_output("nz init_done", bus_nz.init_done_o, 1'b1);
            check_output($sformatf("nz ready %0d", i), bus_nz.late_ready_o, (i == 1) ? 2'b10 : 2'b00);
            check_output($sformatf("nz rd_w_v %0d", i), bus_nz.rd_w_v_o, i == 1);
            if (i == 1) begin
                check_output("nz rd_addr", bus_nz.rd_addr_o, 9);
                check_output("nz rd_data", bus_nz.rd_data_o, 32'h99);
            end
            next_cycle();
        end
        bus_nz.late_v_i = '0;
        #3;
        check_output("init_done after sweep", bus.init_done_o, 1'b1);
        check_output("idle after sweep rd_w_v", bus.rd_w_v_o, 1'b0);
        next_cycle();

        // Directed vectors: pipe priority, alternating grants, single requesters, x0 pass-through.
        tbl[0] = '{1'b1, 5'd5, 32'hAB, 2'b11, 5'd3, 5'd7, 32'h30, 32'h70, 1'b1, 5'd5, 32'hAB, 2'b00, 1'b0};
        tbl[1] = '{1'b0, 5'd0, 32'h0,  2'b11, 5'd3, 5'd7, 32'h30, 32'h70, 1'b1, 5'd3, 32'h30, 2'b01, 1'b0};
        tbl[2] = '{1'b0, 5'd0, 32'h0,  2'b11, 5'd3, 5'd7, 32'h30, 32'h70, 1'b1, 5'd7, 32'h70, 2'b10, 1'b0};
        tbl[3] = '{1'b0, 5'd0, 32'h0,  2'b11, 5'd3, 5'd7, 32'h30, 32'h70, 1'b1, 5'd3, 32'h30, 2'b01, 1'b0};
        tbl[4] = '{1'b0, 5'd0, 32'h0,  2'b11, 5'd3, 5'd7, 32'h30, 32'h70, 1'b1, 5'd7, 32'h70, 2'b10, 1'b0};
        tbl[5] = '{1'b0, 5'd0, 32'h0,  2'b00, 5'd3, 5'd7, 32'h30, 32'h70, 1'b0, 5'd0, 32'h0,  2'b00, 1'b0};
        tbl[6] = '{1'b0, 5'd0, 32'h0,  2'b10, 5'd3, 5'd7, 32'h30, 32'h70, 1'b1, 5'd7, 32'h70, 2'b10, 1'b0};
        tbl[7] = '{1'b0, 5'd0, 32'h0,  2'b01, 5'd3, 5'd7, 32'h30, 32'h70, 1'b1, 5'd3, 32'h30, 2'b01, 1'b0};
        tbl[8] = '{1'b1, 5'd0, 32'h55, 2'b00, 5'd3, 5'd7, 32'h30, 32'h70, 1'b1, 5'd0, 32'h55, 2'b00, 1'b0};
        for (int v = 0; v < 9; v++) begin
            apply_stimulus(tbl[v].pv, tbl[v].pa, tbl[v].pd, tbl[v].lv,
                           tbl[v].la0, tbl[v].la1, tbl[v].ld0, tbl[v].ld1);
            #3;
            check_write($sformatf("vec%0d", v), tbl[v].ev, tbl[v].ea, tbl[v].ed, tbl[v].er, tbl[v].es);
            next_cycle();
        end

        // Starvation: pipe holds the port 8 cycles while port 0 waits.
        for (int k = 0; k < 8; k++) begin
            apply_stimulus(1'b1, aw'(k + 1), dw'(32'h100 + k), 2'b01, 5'd4, 5'd0, 32'h44, 32'h0);
            #3;
            check_write($sformatf("starve%0d", k), 1'b1, aw'(k + 1), dw'(32'h100 + k), 2'b00, 1'b0);
            next_cycle();
        end
        apply_stimulus(1'b0, '0, '0, 2'b01, 5'd4, 5'd0, 32'h44, 32'h0);
        #3;
        check_write("starve grant", 1'b1, 5'd4, 32'h44, 2'b01, 1'b1);
        next_cycle();
        apply_stimulus(1'b0, '0, '0, 2'b00, '0, '0, '0, '0);
        #3;
        check_write("starve release", 1'b0, '0, '0, 2'b00, 1'b0);
        next_cycle();

        // Reset pulsed mid-sweep at address 12 restarts a full sweep.
        reset_n = 1'b0;
        next_cycle();
        reset_n = 1'b1;
        for (int i = 0; i <= 12; i++) begin
            #3;
            check_output($sformatf("pre-pulse addr %0d", i), bus.rd_addr_o, i);
            if (i == 12) reset_n = 1'b0;
            next_cycle();
        end
        reset_n = 1'b1;
        check_sweep("restart");
        next_cycle();

        // Randomized traffic against a scheduler model starting from a fresh reset state.
        ptr = 0;
        starve = 0;
        for (int p = 0; p < np; p++) begin
            pend[p] = 1'b0; paddr[p] = '0; pdata[p] = '0;
        end
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < np; p++) begin
                if (!pend[p] && ($urandom_range(0, 2) == 0)) begin
                    pend[p]  = 1'b1;
                    paddr[p] = aw'($urandom_range(0, nregs - 1));
                    pdata[p] = $urandom;
                end
            end
            pv = ((c / 50) % 2 == 0) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 3);
            pa = aw'($urandom_range(0, nregs - 1));
            pd = $urandom;
            for (int p = 0; p < np; p++) lv[p] = pend[p];
            apply_stimulus(pv, pa, pd, lv, paddr[0], paddr[1], pdata[0], pdata[1]);

            g  = -1;
            er = '0;
            if (!pv) begin
                for (int k = 0; k < np; k++) begin
                    if (g < 0 && pend[(ptr + k) % np]) g = (ptr + k) % np;
                end
            end
            if (g >= 0) er[g] = 1'b1;
            #3;
            if (pv)
                check_write($sformatf("rand%0d", c), 1'b1, pa, pd, er, starve >= starve_lim);
            else if (g >= 0)
                check_write($sformatf("rand%0d", c), 1'b1, paddr[g], pdata[g], er, starve >= starve_lim);
            else
                check_write($sformatf("rand%0d", c), 1'b0, '0, '0, er, starve >= starve_lim);

            if (g >= 0) begin
                ptr      = (g + 1) % np;
                starve   = 0;
                pend[g]  = 1'b0;
            end else if (lv != '0) begin
                starve = (starve + 1 > starve_lim) ? starve_lim : starve + 1;
            end
            next_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/bp_be_rf_write_sched.md
# bp_be_rf_write_sched

Write-port scheduler for the backend integer/FP register file. Merges the in-order pipeline writeback with several variable-latency "late" writeback sources (divider, FP long-op, load miss) onto the regfile's single rd write port. After reset it sweeps every register to zero before releasing the port. It sits between the writeback stage and the regfile write bus.

## Interface
- bp_params_p, e_bp_default_cfg, processor config; supplies reg_addr_width_gp.
- data_width_p, none (required), write data width.
- late_ports_p, 2, number of late writeback requesters (≥1).
- init_zero_p, 1, 1 = zero-sweep after reset; 0 = skip straight to run.
- starve_limit_p, 8, consecutive lost cycles before a pipeline stall is requested (≥1).
- clk_i  in  1  clock; only clock.
- reset_n_i  in  1  reset; synchronous, active-low.
- pipe_v_i  in  1  pipeline writeback valid; highest priority, no backpressure.
- pipe_addr_i  in  reg_addr_width_gp  pipeline rd address.
- pipe_data_i  in  data_width_p  pipeline rd data.
- late_v_i  in  late_ports_p  late request valid, one per port.
- late_addr_i  in  late_ports_p x reg_addr_width_gp  late rd addresses.
- late_data_i  in  late_ports_p x data_width_p  late rd data.
- late_ready_o  out  late_ports_p  one-hot grant; transfer on v & ready.
- rd_w_v_o  out  1  regfile write valid.
- rd_addr_o  out  reg_addr_width_gp  regfile write address.
- rd_data_o  out  data_width_p  regfile write data.
- init_done_o  out  1  high once regfile usable.
- stall_req_o  out  1  asks the pipeline to hold off writeback.

## Operation
- States: INIT, RUN. Reset (reset_n_i=0) enters INIT if init_zero_p=1, else RUN.
- INIT: sweep counter starts at 0; each cycle rd_w_v_o=1, rd_addr_o=counter, rd_data_o=0; counter +1. After address 2^reg_addr_width_gp−1 is written, go to RUN. late_ready_o=0, init_done_o=0, stall_req_o=0. pipe_v_i in INIT is illegal (assertion); it is ignored.
- RUN: init_done_o=1.
  - pipe_v_i=1: write pipe_addr_i/pipe_data_i; late_ready_o=0.
  - Else if any late_v_i: round-robin grant among valid ports, starting at the pointer. The grantee gets late_ready_o=1 and its addr/data drive the port. The pointer moves to grantee+1 (mod late_ports_p).
  - Else: rd_w_v_o=0.
- Late handshake: valid must stay high with stable addr/data until ready. Ready may depend combinationally on valid; valid must not depend on ready.
- Starvation counter:
  - Increments (saturating at starve_limit_p) each RUN cycle with any late_v_i=1 and no late grant.
  - Clears on any late grant.
  - stall_req_o is registered: high the cycle after the counter reaches starve_limit_p, and stays high until the cycle after a late grant.
  - stall_req_o is advisory; if pipe_v_i still arrives, the pipeline still wins.
- Writes to x0 pass through unchanged; zeroing x0 on read is the regfile's job.
- Reset mid-operation:
  - Sweep restarts from address 0.
  - Pointer, counter and stall_req_o are cleared.
  - In-flight late requests are dropped; requesters reset too.

## Timing
- Reset values:
  - State INIT (or RUN if init_zero_p=0), sweep counter 0, rr pointer 0, starvation counter 0, stall_req_o 0.
  - init_done_o = 0 if init_zero_p=1, else 1.
  - late_ready_o all 0.
  - In INIT: rd_w_v_o=1, rd_addr_o=0.
- Zero latency: rd_w_* and late_ready_o are combinational from the current-cycle inputs and state. The regfile write occurs in the request cycle.
- INIT lasts exactly 2^reg_addr_width_gp cycles after reset deasserts; init_done_o rises on the next cycle.
- One write per cycle max; no write is ever lost or duplicated.
- Pointer and counter update on the clock edge after the grant cycle.

## Structure
- State enum e_rf_sched_init / e_rf_sched_run goes in bp_be_pkg (bp_be_defines).
- Sub-module: bsg_arb_round_robin (widths late_ports_p) for the late grant, gated by ~pipe_v_i and RUN.
- Sweep counter: bsg_counter_clear_up. Starvation counter: small saturating register local to the block.

## Test plan
- Reset release, reg_addr_width_gp=5 → 32 cycles of writes, addr 0..31 with data 0; init_done_o rises on cycle 33; late_ready_o stays 0 throughout.
- RUN, pipe_v_i=1 addr 5 data 0xAB, late_v_i=2'b11 → regfile writes addr 5 / 0xAB; late_ready_o=00.
- Pipe idle, both late valid for 4 cycles → grants 01,10,01,10; 4 writes with the matching addr/data.
- pipe_v_i held high 8 cycles with late_v_i[0]=1 → stall_req_o rises on cycle 9. Then pipe drops → port 0 granted; stall_req_o falls the next cycle.
- reset_n_i pulsed low mid-sweep at address 12 → sweep restarts at 0, full 32-cycle INIT.
- init_zero_p=0 → init_done_o=1 out of reset; a late request is granted in its first valid cycle.
